// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: sums N_VOICES samples fetched over a registered
// read port, applies master volume, saturates to WIDTH bits and strobes the result.
module voice_mixer #(
    parameter int WIDTH     = 24,
    parameter int N_VOICES  = 16,
    parameter int VOL_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_tick,
    input  logic [VOL_WIDTH-1:0]        volume,
    output logic [$clog2(N_VOICES)-1:0] voice_idx,
    input  logic signed [WIDTH-1:0]     voice_sample,
    output logic signed [WIDTH-1:0]     sample_out,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IDX_W  = $clog2(N_VOICES);
    localparam int CNT_W  = IDX_W + 1;
    localparam int ACC_W  = WIDTH + IDX_W;
    localparam int PROD_W = ACC_W + VOL_WIDTH + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_VOICES);

    localparam logic signed [PROD_W-1:0] SAT_MAX =
        {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN =
        {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCALE,
        SAT,
        OUT
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [VOL_WIDTH-1:0]     vol_reg;
    logic [CNT_W-1:0]         fetch_cnt_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [PROD_W-1:0] prod_reg;

    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [PROD_W-1:0] acc_ext;
    logic signed [PROD_W-1:0] vol_ext;
    logic signed [PROD_W-1:0] shifted;
    logic signed [WIDTH-1:0]  sat_value;

    // Fetch cycle k presents index min(k, N-1) and adds the sample read in cycle k-1.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sample_tick) state_next = FETCH;
            FETCH:   if (fetch_cnt_reg == LAST_CNT) state_next = SCALE;
            SCALE:   state_next = SAT;
            SAT:     state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample_valid = 1'b0;
        busy         = 1'b0;
        if (state_reg == OUT) sample_valid = 1'b1;
        if (state_reg != IDLE) busy = 1'b1;
    end

    always_comb begin
        sample_ext = {{(ACC_W-WIDTH){voice_sample[WIDTH-1]}}, voice_sample};
        acc_ext    = {{(PROD_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
        vol_ext    = {{(PROD_W-VOL_WIDTH){1'b0}}, vol_reg};
        shifted    = prod_reg >>> VOL_WIDTH;
        if (shifted > SAT_MAX) begin
            sat_value = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_value = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_value = shifted[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            vol_reg       <= '0;
            fetch_cnt_reg <= '0;
            acc_reg       <= '0;
            prod_reg      <= '0;
            voice_idx     <= '0;
            sample_out    <= '0;
            overrun       <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (sample_tick) begin
                        vol_reg       <= volume;
                        acc_reg       <= '0;
                        voice_idx     <= '0;
                        fetch_cnt_reg <= '0;
                    end
                end
                FETCH: begin
                    fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
                    if (voice_idx != LAST_IDX) voice_idx <= voice_idx + 1'b1;
                    if (fetch_cnt_reg != '0) acc_reg <= acc_reg + sample_ext;
                end
                SCALE: prod_reg <= acc_ext * vol_ext;
                SAT:   sample_out <= sat_value;
                default: ;
            endcase
            // Ticks while busy (including the strobe cycle) are dropped but remembered.
            if (sample_tick && state_reg != IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: registered voice store model plus an
// arithmetic reference of sum * volume / 256 with floor and saturation.
module tb_voice_mixer;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic [7:0]         volume;
    logic [3:0]         voice_idx;
    logic signed [23:0] voice_sample;
    logic signed [23:0] sample_out;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    logic signed [23:0] voices [16];
    int tests = 0;
    int fails = 0;

    voice_mixer #(.WIDTH(24), .N_VOICES(16), .VOL_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .volume(volume),
        .voice_idx(voice_idx), .voice_sample(voice_sample), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Oscillator sample store: one-cycle registered lookup.
    always @(posedge clk) voice_sample <= voices[voice_idx];

    function automatic logic signed [23:0] model_mix(input int vol);
        longint sum = 0;
        longint s;
        for (int i = 0; i < 16; i++) sum += longint'(voices[i]);
        s = (sum * longint'(vol)) >>> 8;
        if (s > 8388607) s = 8388607;
        if (s < -8388608) s = -8388608;
        return 24'(s);
    endfunction

    // One tick in cycle T; observes cycles T+1..T+24.
    task automatic do_mix(input logic [7:0] vol, output int nvalid, output int valid_k,
                          output logic signed [23:0] val, output int busy_err,
                          output int idx_err);
        nvalid = 0; valid_k = -1; val = '0; busy_err = 0; idx_err = 0;
        @(negedge clk);
        sample_tick = 1'b1;
        volume = vol;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (sample_valid) begin
                nvalid++;
                valid_k = k;
                val = sample_out;
            end
            if (busy !== (k <= 20)) busy_err++;
            if (k <= 16 && voice_idx !== 4'(k - 1)) idx_err++;
        end
    endtask

    task automatic check_mix(input string name, input logic [7:0] vol,
                             input logic signed [23:0] expected);
        int nv, vk, be, ie;
        logic signed [23:0] v;
        do_mix(vol, nv, vk, v, be, ie);
        $display("[TB] %s: vol=%0d valid_at=T+%0d out=%0d exp=%0d", name, vol, vk, v, expected);
        tests++;
        if (nv !== 1 || vk !== 20) begin
            fails++;
            $display("FAIL %s latency: valids=%0d at T+%0d, required 1 at T+20", name, nv, vk);
        end
        tests++;
        if (v !== expected) begin
            fails++;
            $display("FAIL %s value: got %0d, required %0d", name, v, expected);
        end
        tests++;
        if (be !== 0) begin
            fails++;
            $display("FAIL %s busy: %0d wrong cycles, required 0", name, be);
        end
        tests++;
        if (ie !== 0) begin
            fails++;
            $display("FAIL %s voice_idx: %0d wrong cycles, required 0", name, ie);
        end
    endtask

    task automatic set_all(input logic signed [23:0] x);
        for (int i = 0; i < 16; i++) voices[i] = x;
    endtask

    task automatic test_reset();
        int nv = 0, nz = 0, nb = 0, no = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sample_valid) nv++;
            if (sample_out !== 24'sd0) nz++;
            if (busy) nb++;
            if (overrun) no++;
        end
        $display("[TB] reset idle: valids=%0d nonzero_out=%0d busy=%0d overrun=%0d", nv, nz, nb, no);
        tests++;
        if (nv !== 0) begin fails++; $display("FAIL reset valid: got %0d strobes, required 0", nv); end
        tests++;
        if (nz !== 0) begin fails++; $display("FAIL reset sample_out: got %0d nonzero, required 0", nz); end
        tests++;
        if (nb !== 0) begin fails++; $display("FAIL reset busy: got %0d high, required 0", nb); end
        tests++;
        if (no !== 0) begin fails++; $display("FAIL reset overrun: got %0d high, required 0", no); end
    endtask

    task automatic test_directed();
        set_all(24'sd1000);
        check_mix("all_1000", 8'd255, 24'sd15937);
        set_all(24'sd0); voices[0] = 24'sd3;
        check_mix("round_pos", 8'd128, 24'sd1);
        voices[0] = -24'sd3;
        check_mix("round_neg", 8'd128, -24'sd2);
        set_all(24'sh7FFFFF);
        check_mix("sat_pos", 8'd255, 24'sh7FFFFF);
        set_all(24'sh800000);
        check_mix("sat_neg", 8'd255, 24'sh800000);
        set_all(24'sd12345);
        check_mix("vol_zero", 8'd0, 24'sd0);
    endtask

    task automatic test_random();
        logic [7:0] vol;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 16; i++) begin
                if (n < 4) voices[i] = 24'(int'($urandom_range(400000, 0)) - 200000);
                else voices[i] = 24'($urandom);
            end
            vol = 8'($urandom);
            check_mix($sformatf("random%0d", n), vol, model_mix(int'(vol)));
        end
    endtask

    task automatic test_overrun_volume_latch();
        int nv = 0, k1 = -1, k2 = -1, pre_ov = 0;
        logic signed [23:0] v1 = '0, v2 = '0, e1, e2;
        set_all(24'sd1000);
        e1 = model_mix(255);
        e2 = model_mix(200);
        @(negedge clk);
        sample_tick = 1'b1;
        volume = 8'd255;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (sample_valid) begin
                nv++;
                if (k1 < 0) begin k1 = k; v1 = sample_out; end
                else begin k2 = k; v2 = sample_out; end
            end
            if (k <= 5 && overrun) pre_ov++;
            sample_tick = (k == 5) || (k == 21);
            if (k == 3) volume = 8'd0;
            if (k == 21) volume = 8'd200;
        end
        $display("[TB] overrun: valids=%0d at T+%0d/T+%0d out=%0d/%0d overrun=%b",
                 nv, k1, k2, v1, v2, overrun);
        tests++;
        if (nv !== 2 || k1 !== 20 || k2 !== 41) begin
            fails++;
            $display("FAIL overrun timing: %0d valids at T+%0d,T+%0d, required 2 at T+20,T+41", nv, k1, k2);
        end
        tests++;
        if (v1 !== e1) begin fails++; $display("FAIL volume latch: got %0d, required %0d", v1, e1); end
        tests++;
        if (v2 !== e2) begin fails++; $display("FAIL post-overrun mix: got %0d, required %0d", v2, e2); end
        tests++;
        if (pre_ov !== 0) begin fails++; $display("FAIL overrun early: high %0d cycles, required 0", pre_ov); end
        tests++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL overrun sticky: got %b, required 1", overrun); end
    endtask

    task automatic test_reset_mid_op();
        int nv = 0, vk = -1, post_bad = 0;
        logic signed [23:0] v = '0, e;
        for (int i = 0; i < 16; i++) voices[i] = 24'(int'($urandom_range(20000, 0)) - 5000);
        e = model_mix(180);
        @(negedge clk);
        sample_tick = 1'b1;
        volume = 8'd99;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            sample_tick = 1'b0;
            if (sample_valid) begin nv++; vk = k; v = sample_out; end
            if (k == 11 && (busy !== 1'b0 || sample_out !== 24'sd0 || overrun !== 1'b0 || voice_idx !== 4'd0))
                post_bad++;
            rst = (k == 10);
            if (k == 12) begin sample_tick = 1'b1; volume = 8'd180; end
        end
        $display("[TB] reset mid-op: valids=%0d at T+%0d out=%0d exp=%0d", nv, vk, v, e);
        tests++;
        if (post_bad !== 0) begin fails++; $display("FAIL mid-op reset state: outputs not cleared at T+11"); end
        tests++;
        if (nv !== 1 || vk !== 32) begin
            fails++;
            $display("FAIL mid-op timing: %0d valids at T+%0d, required 1 at T+32", nv, vk);
        end
        tests++;
        if (v !== e) begin fails++; $display("FAIL mid-op value: got %0d, required %0d", v, e); end
    endtask

    initial begin
        rst = 1'b1;
        sample_tick = 1'b0;
        volume = '0;
        set_all(24'sd0);
        test_reset();
        test_directed();
        test_random();
        test_overrun_volume_latch();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
